// File: rtl/pic_pkg.sv
// Shared types, opcode patterns and strobe decode for the 12-bit PIC instruction sequencer.
package pic_pkg;

  localparam int PC_W_DEF = 9;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_state_e;

  typedef struct packed {
    logic w_we;
    logic f_we;
    logic status_we;
  } strobe_t;

  localparam logic [6:0] OP7_MOVWF  = 7'b0000001;
  localparam logic [6:0] OP7_CLRW   = 7'b0000010;
  localparam logic [6:0] OP7_CLRF   = 7'b0000011;
  localparam logic [5:0] OP6_DECF   = 6'b000011;
  localparam logic [5:0] OP6_ANDWF  = 6'b000101;
  localparam logic [5:0] OP6_XORWF  = 6'b000110;
  localparam logic [5:0] OP6_ADDWF  = 6'b000111;
  localparam logic [5:0] OP6_COMF   = 6'b001001;
  localparam logic [5:0] OP6_INCF   = 6'b001010;
  localparam logic [5:0] OP6_DECFSZ = 6'b001011;
  localparam logic [5:0] OP6_RRF    = 6'b001100;
  localparam logic [5:0] OP6_RLF    = 6'b001101;
  localparam logic [5:0] OP6_INCFSZ = 6'b001111;
  localparam logic [2:0] OP3_BITSET = 3'b010;
  localparam logic [3:0] OP4_BTFSC  = 4'b0110;
  localparam logic [3:0] OP4_BTFSS  = 4'b0111;
  localparam logic [3:0] OP4_RETLW  = 4'b1000;
  localparam logic [3:0] OP4_CALL   = 4'b1001;
  localparam logic [2:0] OP3_GOTO   = 3'b101;
  localparam logic [3:0] OP4_MOVLW  = 4'b1100;
  localparam logic [3:0] OP4_ANDLW  = 4'b1110;
  localparam logic [3:0] OP4_XORLW  = 4'b1111;

  function automatic strobe_t decode_strobes(input logic [11:0] ir);
    strobe_t s;
    logic    d_op;
    s = '0;
    // Byte ops from SUBWF upward carry a destination bit in ir[5].
    d_op = (ir[11:10] == 2'b00) && (ir[9:7] != 3'b000);
    if (d_op) begin
      s.w_we = ~ir[5];
      s.f_we = ir[5];
    end
    if (ir[11:5] == OP7_MOVWF || ir[11:5] == OP7_CLRF || ir[11:9] == OP3_BITSET)
      s.f_we = 1'b1;
    if (ir[11:5] == OP7_CLRW || ir[11:8] inside {OP4_RETLW, OP4_MOVLW, OP4_ANDLW, OP4_XORLW})
      s.w_we = 1'b1;
    if (ir[11:6] inside {OP6_ADDWF, OP6_ANDWF, OP6_COMF, OP6_DECF, OP6_INCF, OP6_XORWF,
                         OP6_RLF, OP6_RRF} ||
        ir[11:5] inside {OP7_CLRF, OP7_CLRW} ||
        ir[11:8] inside {OP4_ANDLW, OP4_XORLW})
      s.status_we = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/pic_stack.sv
// Two-level return-address stack; overflow drops the oldest entry, underflow repeats s0.
module pic_stack
  import pic_pkg::*;
#(
  parameter int W = PC_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_s0;
  logic [W-1:0] r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= '0;
      r_s1 <= '0;
    end else if (push) begin
      r_s1 <= r_s0;
      r_s0 <= din;
    end else if (pop) begin
      r_s0 <= r_s1;
    end
  end

  assign dout = r_s0;

endmodule

// File: rtl/pic_ctrl.sv
// Q1..Q4 instruction sequencer: fetch into IR, decode write strobes, update PC and call stack.
module pic_ctrl
  import pic_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = 9'h0FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [11:0]     prog_data,
  input  logic [7:0]      f_data,
  input  logic            fz,
  output logic [PC_W-1:0] pc_out,
  output logic [11:0]     ir_bus,
  output logic [4:0]      f_addr,
  output logic            alu_lit_sel,
  output logic            w_we,
  output logic            f_we,
  output logic            status_we,
  output logic [1:0]      q_state
);

  q_state_e        r_q, w_q_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc, w_stk_dout;
  logic [11:0]     r_ir, w_ir_nxt;
  logic            r_flush, w_flush_nxt;
  logic            w_push, w_pop;
  strobe_t         w_stb;

  assign w_pc_inc = r_pc + PC_W'(1);

  always_comb begin
    w_q_nxt     = r_q;
    w_ir_nxt    = r_ir;
    w_flush_nxt = r_flush;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_stb       = '0;
    if (run) begin
      unique case (r_q)
        Q1: begin
          w_q_nxt     = Q2;
          w_ir_nxt    = r_flush ? 12'h000 : prog_data;
          w_flush_nxt = 1'b0;
        end
        Q2: w_q_nxt = Q3;
        Q3: w_q_nxt = Q4;
        Q4: begin
          // Retire edge: strobes are live only while run is high here, so a stall repeats nothing.
          w_q_nxt  = Q1;
          w_stb    = decode_strobes(r_ir);
          w_pc_nxt = w_pc_inc;
          if (r_ir[11:9] == OP3_GOTO) begin
            w_pc_nxt    = PC_W'(r_ir[8:0]);
            w_flush_nxt = 1'b1;
          end else if (r_ir[11:8] == OP4_CALL) begin
            w_push      = 1'b1;
            w_pc_nxt    = PC_W'(r_ir[7:0]);
            w_flush_nxt = 1'b1;
          end else if (r_ir[11:8] == OP4_RETLW) begin
            w_pop       = 1'b1;
            w_pc_nxt    = w_stk_dout;
            w_flush_nxt = 1'b1;
          end else if (r_ir[11:6] == OP6_DECFSZ || r_ir[11:6] == OP6_INCFSZ) begin
            w_flush_nxt = fz;
          end else if (r_ir[11:8] == OP4_BTFSC) begin
            w_flush_nxt = ~f_data[r_ir[7:5]];
          end else if (r_ir[11:8] == OP4_BTFSS) begin
            w_flush_nxt = f_data[r_ir[7:5]];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= Q1;
      r_pc    <= RESET_VEC;
      r_ir    <= 12'h000;
      r_flush <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  pic_stack #(.W(PC_W)) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (w_pc_inc),
    .dout (w_stk_dout)
  );

  assign pc_out      = r_pc;
  assign ir_bus      = r_ir;
  assign f_addr      = r_ir[4:0];
  assign alu_lit_sel = r_ir[11];
  assign q_state     = r_q;
  assign w_we        = w_stb.w_we & ~rst;
  assign f_we        = w_stb.f_we & ~rst;
  assign status_we   = w_stb.status_we & ~rst;

endmodule
